// File: rtl/interrupt_controller.sv
// Prioritised, edge-triggered interrupt controller with IE/IF/IME registers and vector dispatch.
// Latency: irq edge -> IF one cycle; IF -> int_req one more; int_ack -> vec_valid next cycle.
// Backpressure: int_req holds until int_ack; optional `INTC_WAKE_EN adds a registered wake output.
module interrupt_controller #(
  parameter int         NUM_IRQ    = 5,
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter logic [7:0] VEC_STRIDE = 8'h08
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [7:0]         wdata,
  input  logic               ie_we,
  input  logic               if_we,
  input  logic               ime_set,
  input  logic               ime_clr,
  output logic [7:0]         ie_q,
  output logic [7:0]         if_q,
  output logic               int_req,
  input  logic               int_ack,
  output logic [15:0]        vec,
  output logic               vec_valid
`ifdef INTC_WAKE_EN
  ,
  output logic               wake
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, VEC} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] ie_r;
  logic [NUM_IRQ-1:0] if_r;
  logic [NUM_IRQ-1:0] irq_d;
  logic               ime;
  logic [7:0]         vec_r;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] win_oh;
  logic [2:0]         winner;
  logic [7:0]         vec_calc;
  logic               dispatch;
  logic [NUM_IRQ-1:0] if_next;

  assign pending = ie_r & if_r;

  // Lowest set pending index wins; scan high to low so the last hit is the lowest.
  always_comb begin
    winner = 3'd0;
    win_oh = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner    = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Vector arithmetic is 8-bit so large bases wrap modulo 256.
  always_comb begin
    vec_calc = VEC_BASE + ({5'b0, winner} * VEC_STRIDE);
  end

  // A dispatch only happens when the request is still valid in the ack cycle.
  always_comb begin
    dispatch = (state == REQ) && ime && (|pending) && int_ack;
  end

  // IF next value: software load, then dispatch clear, then edge set (set wins over both).
  always_comb begin
    if_next = if_we ? wdata[NUM_IRQ-1:0] : if_r;
    if (dispatch) if_next = if_next & ~win_oh;
    if_next = if_next | (irq & ~irq_d);
  end

  // Register file: enables, flags, edge samples and master enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      ie_r  <= '0;
      if_r  <= '0;
      irq_d <= '0;
      ime   <= 1'b0;
    end else begin
      irq_d <= irq;
      if_r  <= if_next;
      if (ie_we) ie_r <= wdata[NUM_IRQ-1:0];
      ime   <= (ime | ime_set) & ~ime_clr & ~dispatch;
    end
  end

  // Dispatch FSM with registered int_req / vec_valid / vec.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      int_req   <= 1'b0;
      vec_valid <= 1'b0;
      vec_r     <= 8'h00;
    end else begin
      vec_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ime && (|pending)) begin
            state   <= REQ;
            int_req <= 1'b1;
          end
        end
        REQ: begin
          if (!ime || !(|pending)) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else if (int_ack) begin
            state     <= VEC;
            int_req   <= 1'b0;
            vec_valid <= 1'b1;
            vec_r     <= vec_calc;
          end
        end
        VEC: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTC_WAKE_EN
  // Wake tracks any enabled pending flag, independent of IME, for HALT exit.
  always_ff @(posedge clock) begin
    if (reset) wake <= 1'b0;
    else       wake <= |pending;
  end
`endif

  // Readback pads unused flag bits with 1 and unused enable bits with 0.
  always_comb begin
    if_q              = 8'hFF;
    if_q[NUM_IRQ-1:0] = if_r;
    ie_q              = 8'h00;
    ie_q[NUM_IRQ-1:0] = ie_r;
  end

  assign vec = {8'h00, vec_r};

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised and directed bench for interrupt_controller against a behavioural model.
// Second instance exercises NUM_IRQ=8 with a wrapping vector base.
// Wake output is checked only when INTC_WAKE_EN is defined.
module tb_interrupt_controller;

  localparam int N = 5;
  localparam logic [7:0] MASK = 8'h1F;
  localparam int BASE = 8'h40;
  localparam int STRIDE = 8'h08;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, ie_we, if_we, ime_set, ime_clr, int_ack;
  logic [N-1:0] irq;
  logic [7:0] wdata, ie_q, if_q;
  logic int_req, vec_valid;
  logic [15:0] vec;
`ifdef INTC_WAKE_EN
  logic wake;
`endif

  interrupt_controller dut (
    .clock(clock), .reset(reset), .irq(irq), .wdata(wdata),
    .ie_we(ie_we), .if_we(if_we), .ime_set(ime_set), .ime_clr(ime_clr),
    .ie_q(ie_q), .if_q(if_q), .int_req(int_req), .int_ack(int_ack),
    .vec(vec), .vec_valid(vec_valid)
`ifdef INTC_WAKE_EN
    , .wake(wake)
`endif
  );

  logic r8, ie_we8, if_we8, ime_set8, ime_clr8, ack8;
  logic [7:0] irq8, w8, ie_q8, if_q8;
  logic req8, vv8;
  logic [15:0] vec8;
`ifdef INTC_WAKE_EN
  logic wake8;
`endif

  interrupt_controller #(.NUM_IRQ(8), .VEC_BASE(8'hF0), .VEC_STRIDE(8'h08)) dut8 (
    .clock(clock), .reset(r8), .irq(irq8), .wdata(w8),
    .ie_we(ie_we8), .if_we(if_we8), .ime_set(ime_set8), .ime_clr(ime_clr8),
    .ie_q(ie_q8), .if_q(if_q8), .int_req(req8), .int_ack(ack8),
    .vec(vec8), .vec_valid(vv8)
`ifdef INTC_WAKE_EN
    , .wake(wake8)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: phase 0 = quiet, 1 = requesting the CPU, 2 = vector being presented.
  logic [7:0] m_ie, m_if, m_prev;
  bit m_ime, m_req, m_vv, m_wake;
  int m_phase;
  logic [15:0] m_vec;

  task automatic model_step();
    logic [7:0] pend, nif, edges;
    int win;
    bit found, nime;
    if (reset) begin
      m_ie = 0; m_if = 0; m_prev = 0; m_ime = 0; m_phase = 0;
      m_vv = 0; m_vec = 0; m_wake = 0;
    end else begin
      edges = {3'b0, irq} & ~m_prev;
      pend  = m_ie & m_if;
      found = 0; win = 0;
      for (int i = 0; i < N; i++) if (pend[i] && !found) begin win = i; found = 1; end
      nif  = if_we ? (wdata & MASK) : m_if;
      nime = (m_ime || ime_set) && !ime_clr;
      m_vv = 0;
      if (m_phase == 0) begin
        if (m_ime && pend != 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (!m_ime || pend == 0) m_phase = 0;
        else if (int_ack) begin
          nif[win] = 1'b0;
          nime = 0;
          m_vec = 16'((BASE + win * STRIDE) % 256);
          m_vv = 1;
          m_phase = 2;
        end
      end else m_phase = 0;
      m_wake = (pend != 0);
      m_if   = nif | edges;
      m_ime  = nime;
      if (ie_we) m_ie = wdata & MASK;
      m_prev = {3'b0, irq};
    end
    m_req = (m_phase == 1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("int_req", {15'b0, int_req}, {15'b0, m_req});
    chk("vec_valid", {15'b0, vec_valid}, {15'b0, m_vv});
    chk("vec", vec, m_vec);
    chk("ie_q", {8'h0, ie_q}, {8'h0, m_ie});
    chk("if_q", {8'h0, if_q}, {8'h0, m_if | ~MASK});
`ifdef INTC_WAKE_EN
    chk("wake", {15'b0, wake}, {15'b0, m_wake});
`endif
  endtask

  task automatic quiet();
    reset = 0; ie_we = 0; if_we = 0; ime_set = 0; ime_clr = 0; int_ack = 0; wdata = 0;
  endtask

  initial begin
    quiet(); irq = 0; reset = 1;
    r8 = 1; ie_we8 = 0; if_we8 = 0; ime_set8 = 0; ime_clr8 = 0; ack8 = 0; irq8 = 0; w8 = 0;
    tick();
    chk("rst_vec", vec, 16'h0000);
    chk("rst_ifq", {8'h0, if_q}, 16'h00E0);
    reset = 0;

    // Single source dispatch
    ie_we = 1; wdata = 8'h1F; tick(); quiet();
    ime_set = 1; tick(); quiet();
    irq = 5'b00100; tick(); irq = 0;
    chk("d1_noreq_yet", {15'b0, int_req}, 16'h0);
    tick();
    chk("d1_req", {15'b0, int_req}, 16'h1);
    int_ack = 1; tick(); quiet();
    chk("d1_vv", {15'b0, vec_valid}, 16'h1);
    chk("d1_vec", vec, 16'h0050);
    chk("d1_if", {8'h0, if_q}, 16'h00E0);
    tick();
    chk("d1_vv_drop", {15'b0, vec_valid}, 16'h0);
    chk("d1_vec_hold", vec, 16'h0050);

    // Two simultaneous edges: lower index first
    ime_set = 1; irq = 5'b10010; tick(); quiet(); irq = 0;
    tick();
    int_ack = 1; tick(); quiet();
    chk("d2_vec", vec, 16'h0048);
    chk("d2_if", {8'h0, if_q}, 16'h00F0);

    // Cancel by clearing IF while requesting
    ime_set = 1; tick(); quiet();
    tick();
    chk("d3_req", {15'b0, int_req}, 16'h1);
    if_we = 1; wdata = 0; tick(); quiet();
    int_ack = 1; tick();
    chk("d3_req_drop", {15'b0, int_req}, 16'h0);
    chk("d3_no_vv", {15'b0, vec_valid}, 16'h0);
    tick(); quiet();
    chk("d3_no_vv2", {15'b0, vec_valid}, 16'h0);

    // Edge beats software clear
    if_we = 1; wdata = 0; irq = 5'b01000; tick(); quiet();
    chk("d4_if", {8'h0, if_q}, 16'h00E8);
    irq = 0; ime_clr = 1; tick(); quiet();

`ifdef INTC_WAKE_EN
    reset = 1; tick(); quiet();
    ie_we = 1; wdata = 8'h01; tick(); quiet();
    irq = 5'b00001; tick(); irq = 0;
    tick();
    chk("wk_wake", {15'b0, wake}, 16'h1);
    chk("wk_noreq", {15'b0, int_req}, 16'h0);
`endif

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) irq = N'($urandom);
      wdata   = 8'($urandom);
      ie_we   = ($urandom_range(0, 15) == 0);
      if_we   = ($urandom_range(0, 11) == 0);
      ime_set = ($urandom_range(0, 3) == 0);
      ime_clr = ($urandom_range(0, 9) == 0);
      int_ack = ($urandom_range(0, 1) == 0);
      tick();
    end
    quiet();

    // Eight-source instance with wrapping vector
    @(posedge clock); #1; r8 = 0;
    ie_we8 = 1; w8 = 8'hFF; @(posedge clock); #1; ie_we8 = 0;
    ime_set8 = 1; @(posedge clock); #1; ime_set8 = 0;
    irq8 = 8'h08; @(posedge clock); #1; irq8 = 0;
    for (int k = 0; k < 10 && !req8; k++) begin
      @(posedge clock); #1;
    end
    chk("w8_req", {15'b0, req8}, 16'h1);
    ack8 = 1; @(posedge clock); #1; ack8 = 0;
    chk("w8_vv", {15'b0, vv8}, 16'h1);
    chk("w8_vec", vec8, 16'h0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
